// File: rtl/box_hit_detector.sv
// box_hit_detector - NCH programmable bounding boxes tested in parallel against a
// stream of (x,y) points, two-cycle latency, with per-box sticky hit flags.
module box_hit_detector #(
  parameter int WIDTH = 10,
  parameter int NCH   = 4,
  parameter int IDXW  = $clog2(NCH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic             cfg_en,
  input  logic [WIDTH-1:0] cfg_x_low,
  input  logic [WIDTH-1:0] cfg_x_delta,
  input  logic [WIDTH-1:0] cfg_y_low,
  input  logic [WIDTH-1:0] cfg_y_delta,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  output logic [NCH-1:0]   out_hit,
  output logic             out_any,
  output logic [IDXW-1:0]  out_first,
  output logic [NCH-1:0]   sticky,
  input  logic             sticky_clr
);

  logic [NCH-1:0]            en_q;
  logic [NCH-1:0][WIDTH-1:0] x_lo_q, x_hi_q, y_lo_q, y_hi_q;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_x_q, s1_y_q;

  logic             out_valid_q, out_any_q;
  logic [NCH-1:0]   out_hit_q, sticky_q;
  logic [IDXW-1:0]  out_first_q;

  logic [WIDTH:0]   x_sum, y_sum;
  logic [WIDTH-1:0] x_hi_d, y_hi_d;
  logic [NCH-1:0]   hit_d, sticky_d;
  logic [IDXW-1:0]  first_d;

  // Far edges saturate at the top of the coordinate range instead of wrapping.
  always_comb begin
    x_sum  = {1'b0, cfg_x_low} + {1'b0, cfg_x_delta};
    y_sum  = {1'b0, cfg_y_low} + {1'b0, cfg_y_delta};
    x_hi_d = x_sum[WIDTH] ? {WIDTH{1'b1}} : x_sum[WIDTH-1:0];
    y_hi_d = y_sum[WIDTH] ? {WIDTH{1'b1}} : y_sum[WIDTH-1:0];
  end

  always_comb begin
    hit_d   = '0;
    first_d = '0;
    for (int i = 0; i < NCH; i++) begin
      hit_d[i] = s1_valid_q && en_q[i] &&
                 (s1_x_q >= x_lo_q[i]) && (s1_x_q <= x_hi_q[i]) &&
                 (s1_y_q >= y_lo_q[i]) && (s1_y_q <= y_hi_q[i]);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit_d[i]) first_d = IDXW'(i);
    end
    sticky_d = (sticky_clr ? '0 : sticky_q) | hit_d;
  end

  // Indices at or above NCH never match any channel, so such writes are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      x_lo_q <= '0;
      x_hi_q <= '0;
      y_lo_q <= '0;
      y_hi_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && (cfg_idx == IDXW'(i))) begin
          en_q[i]   <= cfg_en;
          x_lo_q[i] <= cfg_x_low;
          x_hi_q[i] <= x_hi_d;
          y_lo_q[i] <= cfg_y_low;
          y_hi_q[i] <= y_hi_d;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      out_valid_q <= 1'b0;
      out_hit_q   <= '0;
      out_any_q   <= 1'b0;
      out_first_q <= '0;
      sticky_q    <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_x_q <= in_x;
        s1_y_q <= in_y;
      end
      out_valid_q <= s1_valid_q;
      out_hit_q   <= hit_d;
      out_any_q   <= |hit_d;
      out_first_q <= first_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_hit   = out_hit_q;
  assign out_any   = out_any_q;
  assign out_first = out_first_q;
  assign sticky    = sticky_q;

endmodule
